elevator_request_dispatcher: RTL and testbench

ELEVATOR_REQUEST_DISPATCHER -- requirements
Module: elevator_request_dispatcher

---
 rtl/elevator_request_dispatcher.sv | 142 ++++++++++++++
 tb/tb_elevator_request_dispatcher.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_dispatcher.sv
// Elevator call dispatcher: latches hall calls, sweeps up/down picking the nearest
// call in the travel direction, and holds each served floor for a dwell period.
//
// state        | meaning
// S_IDLE       | no work, or car position invalid; car held at current floor
// S_SERVE_UP   | travelling up toward lowest pending call at/above the car
// S_SERVE_DOWN | travelling down toward highest pending call at/below the car
// S_DWELL      | doors open at a served floor; resumes prior direction afterwards
module elevator_request_dispatcher #(
  parameter int NUM_FLOORS   = 10,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] floor_btn,
  input  logic [3:0]            current_floor,
  input  logic                  door_open,
  output logic [3:0]            requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  busy
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_UP, S_SERVE_DOWN, S_DWELL} state_t;

  state_t                state_q, state_d, hold_q, hold_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr_mask;
  logic [3:0]            req_q, req_d, up_tgt, dn_tgt;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  up_found, dn_found, floor_ok, arrival, moving;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      hold_q    <= S_IDLE;
      pending_q <= '0;
      req_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
    end
  end

  // Nearest pending call at/above and at/below the car.
  always_comb begin
    up_found = 1'b0;
    up_tgt   = '0;
    dn_found = 1'b0;
    dn_tgt   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (4'(i) >= current_floor)) begin
        up_found = 1'b1;
        up_tgt   = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (4'(i) <= current_floor)) begin
        dn_found = 1'b1;
        dn_tgt   = 4'(i);
      end
    end
  end

  assign floor_ok = ({1'b0, current_floor} < 5'(NUM_FLOORS));
  assign moving   = (state_q == S_SERVE_UP) || (state_q == S_SERVE_DOWN);
  assign arrival  = floor_ok && door_open && moving && (current_floor == req_q);

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (arrival && (current_floor == 4'(i))) clr_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    req_d     = req_q;
    cnt_d     = '0;
    // Clearing after the OR makes a same-edge press on the arrival floor lose.
    pending_d = (pending_q | floor_btn) & ~clr_mask;

    if (!floor_ok) begin
      state_d = S_IDLE;
      req_d   = '0;
    end else if (arrival) begin
      state_d = S_DWELL;
      hold_d  = state_q;
      req_d   = current_floor;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d = current_floor;
          if (pending_q != '0) state_d = up_found ? S_SERVE_UP : S_SERVE_DOWN;
        end
        S_SERVE_UP: begin
          if (pending_q == '0) begin
            state_d = S_IDLE;
            req_d   = current_floor;
          end else if (up_found) begin
            req_d = up_tgt;
          end else begin
            state_d = S_SERVE_DOWN;
            req_d   = dn_tgt;
          end
        end
        S_SERVE_DOWN: begin
          if (pending_q == '0) begin
            state_d = S_IDLE;
            req_d   = current_floor;
          end else if (dn_found) begin
            req_d = dn_tgt;
          end else begin
            state_d = S_SERVE_UP;
            req_d   = up_tgt;
          end
        end
        S_DWELL: begin
          req_d = current_floor;
          if (cnt_q == CNT_LAST) state_d = hold_q;
          else                   cnt_d   = cnt_q + CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign requested_floor = req_q;
  assign pending         = pending_q;
  assign dir_up          = (state_q == S_SERVE_UP);
  assign dir_down        = (state_q == S_SERVE_DOWN);
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_elevator_request_dispatcher.sv
// Bench for elevator_request_dispatcher: directed scenarios plus random traffic,
// all cycles compared against a behavioural model of the dispatch rules.
module tb_elevator_request_dispatcher;
  localparam int NF = 10;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] floor_btn;
  logic [3:0]    current_floor;
  logic          door_open;
  logic [3:0]    requested_floor;
  logic [NF-1:0] pending;
  logic          dir_up, dir_down, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: mode 0 idle, 1 going up, 2 going down, 3 doors held open.
  int            m_mode, m_hold, m_cnt, m_req;
  logic [NF-1:0] m_pend;
  int            car;

  elevator_request_dispatcher #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .floor_btn(floor_btn), .current_floor(current_floor),
    .door_open(door_open), .requested_floor(requested_floor), .pending(pending),
    .dir_up(dir_up), .dir_down(dir_down), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int            cur;
    int            lo_up, hi_dn;
    logic [NF-1:0] nxt;
    bit            moving, arrive;
    cur    = int'(current_floor);
    lo_up  = -1;
    hi_dn  = -1;
    for (int f = NF - 1; f >= 0; f--) if (m_pend[f] && f >= cur) lo_up = f;
    for (int f = 0; f < NF; f++)      if (m_pend[f] && f <= cur) hi_dn = f;
    moving = (m_mode == 1) || (m_mode == 2);
    arrive = (cur < NF) && door_open && moving && (cur == m_req);
    nxt    = m_pend | floor_btn;
    if (arrive) nxt[cur] = 1'b0;
    if (cur >= NF) begin
      m_mode = 0; m_req = 0;
    end else if (arrive) begin
      m_hold = m_mode; m_mode = 3; m_cnt = 0; m_req = cur;
    end else if (m_mode == 0) begin
      m_req = cur;
      if (m_pend != 0) m_mode = (lo_up >= 0) ? 1 : 2;
    end else if (m_mode == 3) begin
      m_req = cur;
      if (m_cnt == DW - 1) m_mode = m_hold;
      else m_cnt++;
    end else if (m_pend == 0) begin
      m_mode = 0; m_req = cur;
    end else if (m_mode == 1) begin
      if (lo_up >= 0) m_req = lo_up;
      else begin m_mode = 2; m_req = hi_dn; end
    end else begin
      if (hi_dn >= 0) m_req = hi_dn;
      else begin m_mode = 1; m_req = lo_up; end
    end
    m_pend = nxt;
  endtask

  task automatic compare_all();
    check("pending", 32'(pending), 32'(m_pend));
    check("requested_floor", 32'(requested_floor), 32'(m_req));
    check("dir_up", 32'(dir_up), 32'(m_mode == 1));
    check("dir_down", 32'(dir_down), 32'(m_mode == 2));
    check("busy", 32'(busy), 32'(m_mode != 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drive(input logic [NF-1:0] btn, input int cur, input logic door);
    floor_btn     = btn;
    current_floor = 4'(cur);
    door_open     = door;
  endtask

  // Asserted between edges: outputs must clear without any clock.
  task automatic do_reset();
    reset  = 1'b0;
    m_mode = 0; m_hold = 0; m_cnt = 0; m_req = 0; m_pend = '0;
    #1;
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_req", 32'(requested_floor), 32'h0);
    check("rst_dirs", 32'({dir_up, dir_down, busy}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    drive('0, 0, 1'b0);
    reset = 1'b0;
    #2;
    do_reset();

    // Single call from floor 0 to 5, served and dwelled.
    drive('0, 0, 1'b0); cycle();
    drive(NF'(1 << 5), 0, 1'b0); cycle();
    check("press5_pending", 32'(pending), 32'h020);
    drive('0, 0, 1'b0); run(2);
    check("press5_target", 32'(requested_floor), 32'd5);
    check("press5_up", 32'(dir_up), 32'd1);
    drive('0, 5, 1'b1); cycle();
    check("arr5_pending", 32'(pending), 32'h0);
    drive('0, 5, 1'b0); run(6);
    check("arr5_idle", 32'(busy), 32'd0);

    // Intermediate call retargets the car, then original target resumes.
    do_reset();
    drive(NF'(1 << 7), 2, 1'b0); cycle();
    drive('0, 2, 1'b0); run(3);
    check("to7_target", 32'(requested_floor), 32'd7);
    drive(NF'(1 << 4), 2, 1'b0); cycle();
    drive('0, 2, 1'b0); cycle();
    check("retarget4", 32'(requested_floor), 32'd4);
    drive('0, 4, 1'b1); cycle();
    drive('0, 4, 1'b0); run(6);
    check("resume7", 32'(requested_floor), 32'd7);
    drive('0, 7, 1'b1); cycle();
    drive('0, 7, 1'b0); run(6);

    // Car at 6 with calls at 1 and 8: up first, then down.
    do_reset();
    drive(NF'((1 << 1) | (1 << 8)), 6, 1'b0); cycle();
    drive('0, 6, 1'b0); run(3);
    check("sweep_up8", 32'(requested_floor), 32'd8);
    drive('0, 8, 1'b1); cycle();
    drive('0, 8, 1'b0); run(6);
    check("sweep_down", 32'(dir_down), 32'd1);
    check("sweep_tgt1", 32'(requested_floor), 32'd1);
    drive('0, 1, 1'b1); cycle();
    drive('0, 1, 1'b0); run(6);
    check("sweep_done", 32'({busy, pending}), 32'h0);

    // Press on the arrival floor in the same edge is lost.
    do_reset();
    drive(NF'(1 << 3), 0, 1'b0); cycle();
    drive('0, 0, 1'b0); run(3);
    drive(NF'(1 << 3), 3, 1'b1); cycle();
    check("same_edge_clr", 32'(pending[3]), 32'd0);
    drive('0, 3, 1'b0); run(6);

    // Out-of-range position while going down.
    do_reset();
    drive(NF'(1 << 1), 5, 1'b0); cycle();
    drive('0, 5, 1'b0); run(3);
    check("bad_pre_down", 32'(dir_down), 32'd1);
    drive('0, 12, 1'b0); cycle();
    check("bad_idle", 32'(busy), 32'd0);
    check("bad_req", 32'(requested_floor), 32'd0);
    check("bad_pending", 32'(pending), 32'h002);
    drive('0, 5, 1'b0); run(2);
    drive('0, 1, 1'b1); cycle();
    drive('0, 1, 1'b0); run(6);

    // Async reset in the middle of a dwell with calls outstanding.
    do_reset();
    drive(NF'(10'h104), 5, 1'b0); cycle();
    drive('0, 5, 1'b0); run(3);
    drive('0, 8, 1'b1); cycle();
    drive(NF'(1 << 8), 8, 1'b0); cycle();
    check("dwell_pending", 32'(pending), 32'h104);
    do_reset();
    drive('0, 8, 1'b0); run(5);
    check("post_rst_quiet", 32'({busy, pending}), 32'h0);

    // Random traffic with a simple car that walks toward the model target.
    do_reset();
    car = 0;
    for (int k = 0; k < 800; k++) begin
      logic [NF-1:0] rb;
      bit            glitch, dr;
      int            cur;
      rb     = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
      glitch = ($urandom_range(0, 60) == 0);
      cur    = glitch ? $urandom_range(NF, 15) : car;
      dr     = !glitch && ((m_mode == 1) || (m_mode == 2)) && (car == m_req)
               && ($urandom_range(0, 1) == 1);
      drive(rb, cur, dr);
      cycle();
      if (((m_mode == 1) || (m_mode == 2)) && (car != m_req) && ($urandom_range(0, 2) == 0))
        car = (m_req > car) ? car + 1 : car - 1;
      if ($urandom_range(0, 300) == 0) begin
        do_reset();
        car = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
